huc_timer_irqctl: RTL
=====================

Name: huc_timer_irqctl

Overview:
- Timer and interrupt-controller peripheral for the HuC6280 I/O page. It replaces the TIMER stub in the memory model's I/O decode.
- Sits directly downstream of the physical address bus, on the same 21-bit addr/dIn/re/we bus the memory model consumes.
- Decodes the timer window (0x1FEC00–0x1FEFFF) and the interrupt window (0x1FF400–0x1FF7FF) itself.
- Returns registered read data plus a select flag, so the memory model can mux it onto dOut. Drives masked interrupt lines to the CPU core.

Parameters:
- PRESCALE, 1024, clk cycles per timer decrement; must be ≥2. Benches override it to a small value.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- addr  input  21  physical address, same bus as the memory model.
- dIn  input  8  write data.
- re  input  1  read strobe, sampled at posedge.
- we  input  1  write strobe, sampled at posedge.
- dOut  output  8  registered read data; valid the cycle after an accepted read.
- sel  output  1  high for exactly the cycle in which dOut carries this block's read data.
- irq1_in  input  1  raw IRQ1 request (VDC), active-high level.
- irq2_in  input  1  raw IRQ2 request (external), active-high level.
- tiq  output  1  timer interrupt to CPU: tiq_pend & ~mask[2].
- irq1  output  1  irq1_in & ~mask[1].
- irq2  output  1  irq2_in & ~mask[0].

Behaviour:
- Decode:
  - io = addr[20:13]==8'hFF.
  - Timer window: io && addr[12:10]==3'b011; port = addr[0].
  - IRQ window: io && addr[12:10]==3'b101; register = addr[1:0].
  - Access accepted only if exactly one of re/we is high. If re&we, neither happens: no state change, sel stays 0.
- Registers:
  - reload[6:0]: written from dIn[6:0] via timer port 0. Read of port 0 or 1 returns {1'b0,count}.
  - en: written from dIn[0] via timer port 1.
  - mask[2:0]: written from dIn[2:0] via IRQ reg 2; reads return {5'b0,mask}.
  - IRQ reg 3: read returns {5'b0,tiq_pend,irq1_in,irq2_in} (irq1_in/irq2_in raw). Any write clears tiq_pend (ack).
  - IRQ regs 0/1: read 8'h00; writes ignored.
- Read timing:
  - Accepted read in either window at edge N → dOut and sel=1 at edge N+1 (1-cycle latency).
  - Otherwise dOut=8'h00, sel=0.
  - Reads have no side effects.
- Timer:
  - en 0→1 write: count<=reload, prescaler<=0.
  - en 1→1 write: no effect.
  - en=0: count and prescaler hold.
  - While en=1, prescaler increments each clk. At prescaler==PRESCALE-1 (tick) it wraps to 0 and:
    - count!=0: count<=count-1.
    - count==0: count<=reload and tiq_pend<=1.
  - Period = (reload+1)*PRESCALE clk cycles. reload==0 gives an underflow every tick.
  - Writing reload while running affects only the next reload; count is unchanged.
- Simultaneous events:
  - Ack write and underflow on the same edge: tiq_pend ends 1 (set wins).
  - en 0→1 write coincides with nothing; prescaler is 0 on restart.
  - en 1→0 write on a tick edge: the tick is discarded, and count/prescaler keep their pre-edge values.
  - mask changes take effect on irq outputs the cycle after the write.
- Reset (rst=1 at posedge, any state, including mid-count):
  - reload=0, count=0, prescaler=0, en=0, tiq_pend=0, mask=3'b111.
  - dOut=8'h00, sel=0, so tiq/irq1/irq2=0.
- Outputs tiq/irq1/irq2 are combinational from registered state and the raw inputs; no extra latency.

Test Plan:
- Reset value check, PRESCALE=4: assert rst 1 cycle → dOut=00, sel=0, tiq=irq1=irq2=0; read 0x1FF402 → dOut=07 next cycle with sel=1.
- Basic countdown:
  - Setup: write 0x1FEC00=0x02, write 0x1FEC01=0x01, write 0x1FF402=0x00.
  - Count reads 2,1,0 across ticks at 4-cycle spacing.
  - On the 3rd tick: tiq=1, count=2, read 0x1FF403 returns 0x04.
  - Write 0x1FF403=0xFF → tiq=0 next cycle.
- Ack/underflow collision: with reload=0 and running, issue ack write on the exact tick edge → tiq_pend stays 1, tiq stays 1.
- Masking and raw status:
  - Drive irq1_in=1, irq2_in=1 with mask=3'b011 → irq1=irq2=0.
  - Read 0x1FF403 → 0x03.
  - Write mask=0 → irq1=irq2=1 the next cycle.
- Stop/restart and reload-while-running:
  - Running with reload=5: write reload=1 → current count continues to 0, then reloads 1.
  - Write en=0 → count frozen across 20 cycles.
  - Write en=1 → count=1, prescaler restarted (next decrement exactly 4 cycles later).
- Illegal/out-of-window accesses:
  - re&we on 0x1FEC00 → reload unchanged, sel=0.
  - Read 0x1F0000 or 0x1FE000 → sel=0, dOut=00.
  - Read 0x1FF400 → dOut=00, sel=1.
  - rst asserted mid-count → all reset values next cycle, tiq=0.

Source files
------------

// File: rtl/huc_timer_irqctl.sv
// HuC6280 timer and interrupt controller for the I/O page.
// Decodes the timer window (0x1FEC00-0x1FEFFF) and the interrupt window
// (0x1FF400-0x1FF7FF). Read data is returned one cycle late, together with
// a select flag. The interrupt lines to the CPU are masked copies of the
// pending and raw requests.
module huc_timer_irqctl #(
    parameter int PRESCALE = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [20:0] addr,
    input  logic [7:0]  dIn,
    input  logic        re,
    input  logic        we,
    output logic [7:0]  dOut,
    output logic        sel,
    input  logic        irq1_in,
    input  logic        irq2_in,
    output logic        tiq,
    output logic        irq1,
    output logic        irq2
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [6:0]    reload_q, reload_d;
    logic [6:0]    count_q, count_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          en_q, en_d;
    logic          pend_q, pend_d;
    logic [2:0]    mask_q, mask_d;
    logic [7:0]    dout_q, dout_d;
    logic          sel_q, sel_d;

    logic          io_s, tmr_win_s, irq_win_s, rd_ok_s, wr_ok_s;
    logic          run_s, underflow_s;
    logic [7:0]    rdata_s;

    // Address decode. A strobe only counts when exactly one of re/we is high.
    always_comb begin
        io_s      = (addr[20:13] == 8'hFF);
        tmr_win_s = io_s && (addr[12:10] == 3'b011);
        irq_win_s = io_s && (addr[12:10] == 3'b101);
        rd_ok_s   = re && !we;
        wr_ok_s   = we && !re;
    end

    // Timer, pending flag, reload and mask next-state logic.
    always_comb begin
        reload_d    = reload_q;
        count_d     = count_q;
        pre_d       = pre_q;
        en_d        = en_q;
        pend_d      = pend_q;
        mask_d      = mask_q;
        underflow_s = 1'b0;
        run_s       = en_q;

        // Enable port: a 0->1 write restarts from reload with a fresh
        // prescaler; a 1->0 write freezes everything, discarding any tick
        // due on this edge. A 1->1 or 0->0 write leaves the timer as it is.
        if (wr_ok_s && tmr_win_s && addr[0] && dIn[0] && !en_q) begin
            count_d = reload_q;
            pre_d   = '0;
            en_d    = 1'b1;
            run_s   = 1'b0;
        end else if (wr_ok_s && tmr_win_s && addr[0] && !dIn[0] && en_q) begin
            en_d  = 1'b0;
            run_s = 1'b0;
        end else begin
            run_s = en_q;
        end

        if (run_s) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                if (count_q == 7'd0) begin
                    count_d     = reload_q;
                    underflow_s = 1'b1;
                end else begin
                    count_d = count_q - 7'd1;
                end
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end else begin
            pre_d = pre_d;
        end

        // Reload only feeds the next underflow; the running count is untouched.
        if (wr_ok_s && tmr_win_s && !addr[0]) begin
            reload_d = dIn[6:0];
        end else begin
            reload_d = reload_q;
        end

        if (wr_ok_s && irq_win_s && (addr[1:0] == 2'd2)) begin
            mask_d = dIn[2:0];
        end else begin
            mask_d = mask_q;
        end

        // An underflow on the same edge as an acknowledge keeps the request.
        if (underflow_s) begin
            pend_d = 1'b1;
        end else if (wr_ok_s && irq_win_s && (addr[1:0] == 2'd3)) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    // Read mux and registered read-data/select for the next cycle.
    always_comb begin
        rdata_s = 8'h00;
        dout_d  = 8'h00;
        sel_d   = 1'b0;
        if (tmr_win_s) begin
            rdata_s = {1'b0, count_q};
        end else if (irq_win_s) begin
            case (addr[1:0])
                2'd2:    rdata_s = {5'b00000, mask_q};
                2'd3:    rdata_s = {5'b00000, pend_q, irq1_in, irq2_in};
                default: rdata_s = 8'h00;
            endcase
        end else begin
            rdata_s = 8'h00;
        end
        if (rd_ok_s && (tmr_win_s || irq_win_s)) begin
            dout_d = rdata_s;
            sel_d  = 1'b1;
        end else begin
            dout_d = 8'h00;
            sel_d  = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            reload_q <= 7'd0;
            count_q  <= 7'd0;
            pre_q    <= '0;
            en_q     <= 1'b0;
            pend_q   <= 1'b0;
            mask_q   <= 3'b111;
            dout_q   <= 8'h00;
            sel_q    <= 1'b0;
        end else begin
            reload_q <= reload_d;
            count_q  <= count_d;
            pre_q    <= pre_d;
            en_q     <= en_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            dout_q   <= dout_d;
            sel_q    <= sel_d;
        end
    end

    assign dOut = dout_q;
    assign sel  = sel_q;
    assign tiq  = pend_q & ~mask_q[2];
    assign irq1 = irq1_in & ~mask_q[1];
    assign irq2 = irq2_in & ~mask_q[0];

endmodule
